// File: rtl/ahim_config_pkg.sv
// rtl/ahim_config_pkg.sv - system-wide configuration constants shared by the HPS PIO path
package ahim_config_pkg;

    localparam int PIO_DATA_WIDTH = 32;

endpackage

// File: rtl/ocr_filo_pkg.sv
// rtl/ocr_filo_pkg.sv - types and defaults for the OCR result LIFO
package ocr_filo_pkg;

    import ahim_config_pkg::*;

    localparam int FILO_DEPTH = 16;

    typedef logic [PIO_DATA_WIDTH-1:0] filo_word_t;
    typedef logic [$clog2(FILO_DEPTH+1)-1:0] filo_ptr_t;

endpackage

// File: rtl/ocr_filo_mem.sv
// rtl/ocr_filo_mem.sv - one-write one-read synchronous array backing the OCR result LIFO
module ocr_filo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk_in,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; no reset so the array maps onto block RAM
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ocr_result_filo.sv
// rtl/ocr_result_filo.sv - newest-first result buffer between OCR receive unit and HPS PIO (optional OCR_FILO_PEAK_EN)
module ocr_result_filo
    import ocr_filo_pkg::*;
#(
    parameter int DEPTH = FILO_DEPTH,
    parameter int WIDTH = ahim_config_pkg::PIO_DATA_WIDTH
) (
    input  logic                       clk_in,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_to_FILO,
    input  logic                       push_filo,
    input  logic                       Clear_buff,
    input  logic                       pop_req,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] peak_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH+1);

    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_m1;
    logic [PW-1:0]    sp_p1;
    logic             pop_req_d;
    logic             pop_fire;
    logic             push_only;
    logic             pop_only;
    logic             push_pop;
    logic             is_full;
    logic             is_empty;
    logic             mem_wr_en;
    logic             mem_rd_en;
    logic [WIDTH-1:0] mem_rd_data;
    // data_out comes from the RAM read register or from the bypass register
    logic             src_mem_q;
    logic [WIDTH-1:0] bypass_q;

    assign pop_fire  = pop_req & ~pop_req_d;
    assign push_only = push_filo & ~pop_fire;
    assign pop_only  = pop_fire & ~push_filo;
    assign push_pop  = push_filo & pop_fire;
    assign is_full   = (sp == PW'(DEPTH));
    assign is_empty  = (sp == '0);
    assign sp_m1     = sp - PW'(1);
    assign sp_p1     = sp + PW'(1);

    assign mem_wr_en = ~Clear_buff & push_only & ~is_full;
    assign mem_rd_en = ~Clear_buff & pop_only & ~is_empty;

    ocr_filo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_in  (clk_in),
        .wr_en   (mem_wr_en),
        .wr_addr (sp[AW-1:0]),
        .wr_data (data_to_FILO),
        .rd_en   (mem_rd_en),
        .rd_addr (sp_m1[AW-1:0]),
        .rd_data (mem_rd_data)
    );

    // Stack pointer, pop edge detect, sticky errors and data_out source select
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sp         <= '0;
            pop_req_d  <= 1'b0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            src_mem_q  <= 1'b0;
            bypass_q   <= '0;
        end else begin
            pop_req_d <= pop_req;
            if (Clear_buff) begin
                sp         <= '0;
                data_valid <= 1'b0;
                overflow   <= 1'b0;
                underflow  <= 1'b0;
            end else begin
                data_valid <= pop_fire;
                if (push_only) begin
                    if (is_full) begin
                        overflow <= 1'b1;
                    end else begin
                        sp <= sp_p1;
                    end
                end
                if (pop_only) begin
                    if (is_empty) begin
                        underflow <= 1'b1;
                        bypass_q  <= '0;
                        src_mem_q <= 1'b0;
                    end else begin
                        sp        <= sp_m1;
                        src_mem_q <= 1'b1;
                    end
                end
                if (push_pop) begin
                    bypass_q  <= data_to_FILO;
                    src_mem_q <= 1'b0;
                end
            end
        end
    end

    assign data_out   = src_mem_q ? mem_rd_data : bypass_q;
    assign word_count = sp;
    assign empty      = is_empty;
    assign full       = is_full;

`ifdef OCR_FILO_PEAK_EN
    logic [PW-1:0] peak_q;

    // High-water mark of occupancy, raised on each accepted push
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else if (Clear_buff) begin
            peak_q <= '0;
        end else if (mem_wr_en && (sp_p1 > peak_q)) begin
            peak_q <= sp_p1;
        end
    end

    assign peak_count = peak_q;
`else
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_ocr_result_filo.sv
// tb/tb_ocr_result_filo.sv - directed self-checking bench for ocr_result_filo
module tb_ocr_result_filo;

    logic        clk_in = 1'b0;
    logic        rst;
    logic [31:0] data_to_FILO;
    logic        push_filo;
    logic        Clear_buff;
    logic        pop_req;
    logic [31:0] data_out;
    logic        data_valid;
    logic [4:0]  word_count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic [4:0]  peak_count;

    int tests_run = 0;
    int tests_failed = 0;

    ocr_result_filo dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .data_to_FILO (data_to_FILO),
        .push_filo    (push_filo),
        .Clear_buff   (Clear_buff),
        .pop_req      (pop_req),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .word_count   (word_count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .underflow    (underflow),
        .peak_count   (peak_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        data_to_FILO = w;
        push_filo = 1'b1;
        step();
        push_filo = 1'b0;
    endtask

    task automatic do_clear();
        Clear_buff = 1'b1;
        step();
        Clear_buff = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({data_out, data_valid, word_count, empty, full, overflow, underflow, peak_count} !==
            {32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0})
            begin tests_failed++; $display("FAIL reset_state: dout=%h dv=%b wc=%0d e=%b f=%b ov=%b un=%b pk=%0d expected 0 0 0 1 0 0 0 0", data_out, data_valid, word_count, empty, full, overflow, underflow, peak_count); end
    endtask

    task automatic test_lifo_order();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h33; exp_w[1] = 32'h22; exp_w[2] = 32'h11;
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        tests_run++;
        if (word_count !== 5'd3) begin tests_failed++; $display("FAIL lifo_count: got %0d expected 3", word_count); end
        for (int i = 0; i < 3; i++) begin
            pop_req = 1'b1;
            step();
            tests_run++;
            if (data_out !== exp_w[i] || data_valid !== 1'b1 || word_count !== 5'(2 - i))
                begin tests_failed++; $display("FAIL lifo_pop%0d: dout=%h dv=%b wc=%0d expected %h 1 %0d", i, data_out, data_valid, word_count, exp_w[i], 2 - i); end
            pop_req = 1'b0;
            step();
            tests_run++;
            if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL lifo_dv_fall%0d: got %b expected 0", i, data_valid); end
        end
        tests_run++;
        if (empty !== 1'b1) begin tests_failed++; $display("FAIL lifo_empty: got %b expected 1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 16; i++) push_word(32'(i));
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0 || word_count !== 5'd16)
            begin tests_failed++; $display("FAIL fill16: f=%b ov=%b wc=%0d expected 1 0 16", full, overflow, word_count); end
        push_word(32'hFF);
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b1 || word_count !== 5'd16)
            begin tests_failed++; $display("FAIL overflow: f=%b ov=%b wc=%0d expected 1 1 16", full, overflow, word_count); end
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        tests_run++;
        if (data_out !== 32'h10 || word_count !== 5'd15 || overflow !== 1'b1)
            begin tests_failed++; $display("FAIL overflow_pop: dout=%h wc=%0d ov=%b expected 10 15 1", data_out, word_count, overflow); end
        step();
        do_clear();
        tests_run++;
        if (overflow !== 1'b0 || word_count !== 5'd0 || data_out !== 32'h10)
            begin tests_failed++; $display("FAIL overflow_clear: ov=%b wc=%0d dout=%h expected 0 0 10", overflow, word_count, data_out); end
    endtask

    task automatic test_underflow();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        tests_run++;
        if (data_out !== 32'h0 || data_valid !== 1'b1 || underflow !== 1'b1 || word_count !== 5'd0)
            begin tests_failed++; $display("FAIL underflow: dout=%h dv=%b un=%b wc=%0d expected 0 1 1 0", data_out, data_valid, underflow, word_count); end
        step();
        tests_run++;
        if (data_valid !== 1'b0 || underflow !== 1'b1)
            begin tests_failed++; $display("FAIL underflow_sticky: dv=%b un=%b expected 0 1", data_valid, underflow); end
        do_clear();
    endtask

    task automatic test_pass_through();
        push_word(32'hA1);
        push_word(32'hA2);
        data_to_FILO = 32'hAB;
        push_filo = 1'b1;
        pop_req = 1'b1;
        step();
        push_filo = 1'b0;
        pop_req = 1'b0;
        tests_run++;
        if (data_out !== 32'hAB || data_valid !== 1'b1 || word_count !== 5'd2 || overflow !== 1'b0 || underflow !== 1'b0)
            begin tests_failed++; $display("FAIL pass_through: dout=%h dv=%b wc=%0d ov=%b un=%b expected ab 1 2 0 0", data_out, data_valid, word_count, overflow, underflow); end
        step();
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        tests_run++;
        if (data_out !== 32'hA2 || word_count !== 5'd1)
            begin tests_failed++; $display("FAIL pass_through_next: dout=%h wc=%0d expected a2 1", data_out, word_count); end
        step();
        do_clear();
    endtask

    task automatic test_held_pop_and_clear();
        int pulses;
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push_word(32'hC0 + 32'(i));
        pulses = 0;
        pop_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (data_valid === 1'b1) pulses++;
        end
        pop_req = 1'b0;
        tests_run++;
        if (pulses !== 1 || word_count !== 5'd3 || data_out !== 32'hC3)
            begin tests_failed++; $display("FAIL held_pop: pulses=%0d wc=%0d dout=%h expected 1 3 c3", pulses, word_count, data_out); end
        tests_run++;
        if (underflow !== 1'b1) begin tests_failed++; $display("FAIL held_pre_clear_underflow: got %b expected 1", underflow); end
        do_clear();
        tests_run++;
        if (word_count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || data_valid !== 1'b0 || peak_count !== 5'd0 || data_out !== 32'hC3)
            begin tests_failed++; $display("FAIL clear: wc=%0d e=%b ov=%b un=%b dv=%b pk=%0d dout=%h expected 0 1 0 0 0 0 c3", word_count, empty, overflow, underflow, data_valid, peak_count, data_out); end
    endtask

    task automatic test_async_reset();
        push_filo = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_to_FILO = 32'h50 + 32'(i);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({data_out, data_valid, word_count, empty, full, overflow, underflow, peak_count} !==
            {32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0})
            begin tests_failed++; $display("FAIL async_reset: dout=%h dv=%b wc=%0d e=%b f=%b ov=%b un=%b pk=%0d expected 0 0 0 1 0 0 0 0", data_out, data_valid, word_count, empty, full, overflow, underflow, peak_count); end
        data_to_FILO = 32'h77;
        step();
        rst = 1'b0;
        step();
        push_filo = 1'b0;
        tests_run++;
        if (word_count !== 5'd1) begin tests_failed++; $display("FAIL first_push_after_reset: wc=%0d expected 1", word_count); end
        pop_req = 1'b1;
        step();
        pop_req = 1'b0;
        tests_run++;
        if (data_out !== 32'h77 || word_count !== 5'd0)
            begin tests_failed++; $display("FAIL pop_after_reset: dout=%h wc=%0d expected 77 0", data_out, word_count); end
        step();
    endtask

    task automatic test_peak();
        logic [4:0] exp_peak;
        do_clear();
        for (int i = 0; i < 5; i++) push_word(32'hD0 + 32'(i));
        for (int i = 0; i < 2; i++) begin
            pop_req = 1'b1;
            step();
            pop_req = 1'b0;
            step();
        end
`ifdef OCR_FILO_PEAK_EN
        exp_peak = 5'd5;
`else
        exp_peak = 5'd0;
`endif
        tests_run++;
        if (peak_count !== exp_peak || word_count !== 5'd3)
            begin tests_failed++; $display("FAIL peak: pk=%0d wc=%0d expected %0d 3", peak_count, word_count, exp_peak); end
    endtask

    initial begin
        rst = 1'b1;
        data_to_FILO = '0;
        push_filo = 1'b0;
        Clear_buff = 1'b0;
        pop_req = 1'b0;
        #12;
        test_reset();
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        test_lifo_order();
        test_overflow();
        test_underflow();
        test_pass_through();
        test_held_pop_and_clear();
        test_async_reset();
        test_peak();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ocr_result_filo.md
# ocr_result_filo

Last-in-first-out word buffer between the OCR receive unit and the HPS PIO read path. Captures each packed PIO_DATA_WIDTH result word when the receive unit pulses its push strobe, then returns words newest-first on HPS pop requests. Reports occupancy, full/empty and sticky overflow/underflow errors. Cleared together with the receive unit's buffer.

## Interface
Parameters:
- DEPTH, 16 — number of words stored; power of two, at least 2.
- WIDTH, PIO_DATA_WIDTH — word width, taken from ahim_config_pkg.

Ports:
- clk_in  in  1 — single clock.
- rst  in  1 — reset, asynchronous and active-high.
- data_to_FILO  in  WIDTH — packed character word from the receive unit.
- push_filo  in  1 — write strobe, one word per high cycle.
- Clear_buff  in  1 — synchronous buffer clear.
- pop_req  in  1 — HPS read request, level or pulse. Rising-edge detected internally.
- data_out  out  WIDTH — last popped word.
- data_valid  out  1 — one-cycle strobe: data_out updated.
- word_count  out  $clog2(DEPTH+1) — current occupancy.
- empty  out  1 — word_count == 0.
- full  out  1 — word_count == DEPTH.
- overflow  out  1 — sticky: a push was dropped.
- underflow  out  1 — sticky: a pop arrived while empty.
- peak_count  out  $clog2(DEPTH+1) — highest occupancy since clear. Present only with the macro; otherwise tied to 0.

## Operation
- Storage: DEPTH×WIDTH array plus stack pointer sp, where sp = word_count.
- pop_fire = pop_req & ~pop_req_d. pop_req_d is a register sampling pop_req every cycle. Reset clears pop_req_d.
- Priority per cycle: rst > Clear_buff > push/pop.
- Clear_buff:
  - sp ← 0; overflow, underflow, data_valid and peak_count ← 0.
  - data_out is held.
  - Array contents are don't-care.
  - pop_req_d still samples pop_req.
- Push only:
  - sp < DEPTH: mem[sp] ← data_to_FILO, sp ← sp+1.
  - sp == DEPTH: word dropped, overflow ← 1, sp unchanged.
- Pop only:
  - sp > 0: data_out ← mem[sp-1], sp ← sp-1, data_valid ← 1.
  - sp == 0: data_out ← 0, data_valid ← 1, underflow ← 1.
- Push and pop in the same cycle (pass-through, LIFO-consistent):
  - data_out ← data_to_FILO, data_valid ← 1.
  - sp and the array are unchanged.
  - No overflow or underflow is flagged, at any occupancy.
- data_valid is 0 in every cycle without pop_fire.
- Overflow and underflow stay set until Clear_buff or rst.

## Timing
- Reset values: data_out 0, data_valid 0, word_count 0, empty 1, full 0, overflow 0, underflow 0, peak_count 0.
- Push sampled at edge N → word_count, full and empty reflect it after edge N.
- Pop latency is 1 edge:
  - pop_req rises before edge N → data_out and data_valid are valid after edge N.
  - data_valid falls after edge N+1.
  - A pop_req held high for k cycles produces exactly one pop.
- Back-to-back pops need pop_req low for at least 1 cycle between rises.
- Pushes may arrive on every cycle.
- rst asserted mid-operation clears all state immediately, with no clock needed. The first push is accepted at the first edge after rst deasserts.
- The array has no reset; only the pointer and flags reset.

## Configuration
- OCR_FILO_PEAK_EN defined:
  - peak_count register updates to max(peak_count, next sp) on every accepted push.
  - Cleared by rst and Clear_buff.
- Not defined: peak_count is a constant 0 and no register is inferred.

## Structure
- Shared package ocr_filo_pkg:
  - typedef filo_word_t logic [PIO_DATA_WIDTH-1:0].
  - FILO_DEPTH default constant.
  - typedef filo_ptr_t sized $clog2(FILO_DEPTH+1).
- One sub-module, ocr_filo_mem:
  - Synchronous-write array with one write port and one read port.
  - Read address sp-1 is registered on pop_fire, so it infers block RAM.
  - Top level holds the pointer, edge detect, flags and pass-through mux.

## Test plan
- Push 0x11, 0x22, 0x33 on consecutive cycles, then three separated pops → data_out 0x33, 0x22, 0x11, each with one data_valid pulse. word_count 3→0, empty=1 at end.
- Fill 16 words, then push a 17th word 0xFF → full=1, overflow=1, word_count stays 16. First pop returns word 16, not 0xFF.
- Pop when empty → data_out=0, data_valid=1 for one cycle, underflow=1, word_count=0.
- With 2 words stored, push 0xAB and raise pop_req in the same cycle → data_out=0xAB, word_count stays 2. Next pop returns the second stored word.
- Hold pop_req high 5 cycles with 4 words stored → one pop only, word_count 3. Assert Clear_buff → word_count=0, flags=0, peak_count=0.
- Assert rst mid-push-burst asynchronously → all outputs at reset values before the next edge. With OCR_FILO_PEAK_EN defined, after 5 pushes and 2 pops → peak_count=5.
